// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if
//  Signal bundle around the UART receive frame controller.
//  Line/config : rx_in, prescale, par_en, par_typ          (into controller)
//  Sampler link: sampled_bit                               (into controller)
//                dat_samp_en, edge_cnt, samp_prescale      (out of controller)
//  Word output : p_data, data_valid, par_err, stp_err, busy (out of controller)
//  master = controller side; slave = line/sampler/consumer side.
interface uart_rx_ctrl_if #(
   parameter int PRSC_WIDTH = 6,
   parameter int DATA_WIDTH = 8
);
   logic                  rx_in;
   logic [PRSC_WIDTH-1:0] prescale;
   logic                  par_en;
   logic                  par_typ;
   logic                  sampled_bit;
   logic                  dat_samp_en;
   logic [PRSC_WIDTH-2:0] edge_cnt;
   logic [PRSC_WIDTH-2:0] samp_prescale;
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;
   logic                  busy;

   modport master (
      input  rx_in, prescale, par_en, par_typ, sampled_bit,
      output dat_samp_en, edge_cnt, samp_prescale, p_data, data_valid,
             par_err, stp_err, busy
   );

   modport slave (
      output rx_in, prescale, par_en, par_typ, sampled_bit,
      input  dat_samp_en, edge_cnt, samp_prescale, p_data, data_valid,
             par_err, stp_err, busy
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//  Frame controller for the UART receiver. Drives the 3-sample majority
//  sampler (enable, tick count, half-prescale), detects the start bit,
//  deserializes DATA_WIDTH bits LSB-first, checks optional parity and the
//  stop bit, and presents the word with a one-cycle valid strobe.
//  Ports:
//   clk  - oversample clock (P ticks per UART bit)
//   rst  - asynchronous reset, active high
//   bus  - uart_rx_ctrl_if.master: line/config/sampler inputs, sampler
//          control and received-word outputs
module uart_rx_ctrl #(
   parameter int MAX_PRESCALE = 32,
   parameter int PRSC_WIDTH   = $clog2(MAX_PRESCALE) + 1,
   parameter int DATA_WIDTH   = 8
) (
   input  logic           clk,
   input  logic           rst,
   uart_rx_ctrl_if.master bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int ECW = PRSC_WIDTH - 1;

   logic [2:0]            state;
   logic [PRSC_WIDTH-1:0] p_reg;
   logic                  par_en_r;
   logic                  par_typ_r;
   logic [ECW-1:0]        edge_cnt_r;
   logic [BCW-1:0]        bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] p_data_r;
   logic                  valid_r;
   logic                  par_err_r;
   logic                  stp_err_r;

   logic [PRSC_WIDTH-1:0] p_in;
   logic [PRSC_WIDTH-1:0] edge_ext;
   logic                  at_last;
   logic                  at_stop;
   logic                  exp_par;

   // Even ratio only, clamped to the smallest ratio the sampler window fits in.
   always_comb begin
      // NOTE: default assignment first so no path leaves p_in unassigned (no latch).
      p_in = bus.prescale & ~PRSC_WIDTH'(1);
      if (p_in < PRSC_WIDTH'(8)) p_in = PRSC_WIDTH'(8);
   end

   assign edge_ext = {1'b0, edge_cnt_r};
   assign at_last  = (edge_ext == p_reg - PRSC_WIDTH'(1));
   // Stop bit is judged right after its majority vote completes, leaving half
   // a bit of slack to catch the next start edge on back-to-back frames.
   assign at_stop  = (edge_ext == {1'b0, p_reg[PRSC_WIDTH-1:1]} + PRSC_WIDTH'(2));
   assign exp_par  = par_typ_r ? ~^shift_reg : ^shift_reg;

   // Tick counter: held at 0 while idle, wraps at bit end, and restarts when
   // the stop bit is evaluated early.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_cnt_r <= '0;
      end else if (state == S_IDLE || at_last || (state == S_STOP && at_stop)) begin
         // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
         edge_cnt_r <= '0;
      end else begin
         edge_cnt_r <= edge_cnt_r + ECW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the data path (shift_reg, p_data_r) is reset too, so a mid-frame reset leaves nothing stale on the outputs.
         state     <= S_IDLE;
         p_reg     <= '0;
         par_en_r  <= 1'b0;
         par_typ_r <= 1'b0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         p_data_r  <= '0;
         valid_r   <= 1'b0;
         par_err_r <= 1'b0;
         stp_err_r <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         case (state)
            S_IDLE: begin
               bit_cnt <= '0;
               if (!bus.rx_in) begin
                  state     <= S_START;
                  p_reg     <= p_in;
                  par_en_r  <= bus.par_en;
                  par_typ_r <= bus.par_typ;
                  par_err_r <= 1'b0;
                  stp_err_r <= 1'b0;
               end
            end
            S_START: begin
               // A high vote means the falling edge was a glitch: drop silently.
               if (at_last) state <= bus.sampled_bit ? S_IDLE : S_DATA;
            end
            S_DATA: begin
               if (at_last) begin
                  shift_reg <= {bus.sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                  if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                     bit_cnt <= '0;
                     state   <= par_en_r ? S_PARITY : S_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + BCW'(1);
                  end
               end
            end
            S_PARITY: begin
               if (at_last) begin
                  par_err_r <= (bus.sampled_bit != exp_par);
                  state     <= S_STOP;
               end
            end
            S_STOP: begin
               if (at_stop) begin
                  stp_err_r <= ~bus.sampled_bit;
                  state     <= S_IDLE;
                  if (bus.sampled_bit && !par_err_r) begin
                     p_data_r <= shift_reg;
                     valid_r  <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy          = (state != S_IDLE);
   assign bus.dat_samp_en   = (state != S_IDLE);
   assign bus.edge_cnt      = edge_cnt_r;
   assign bus.samp_prescale = p_reg[PRSC_WIDTH-1:1];
   assign bus.p_data        = p_data_r;
   assign bus.data_valid    = valid_r;
   assign bus.par_err       = par_err_r;
   assign bus.stp_err       = stp_err_r;
endmodule
